// File: rtl/viterbi_pkg.sv
// Shared constants, metric type and trellis helpers for the hard-decision Viterbi datapath.
package viterbi_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned NUM_STATES = 2 ** (K - 1);
  localparam int unsigned BM_W       = 2;
  localparam int unsigned PM_W       = 8;
  localparam int unsigned INIT_PM    = 16;

  typedef logic [PM_W-1:0] pm_t;

  // Predecessor reached by shifting in a 0 at the top of the state register.
  function automatic int unsigned pred0(input int unsigned n);
    return n >> 1;
  endfunction

  function automatic int unsigned pred1(input int unsigned n, input int unsigned num_states);
    return (n >> 1) | (num_states >> 1);
  endfunction

endpackage

// File: rtl/acs_node.sv
// One destination state: add branch metrics to both predecessor metrics, keep the smaller.
module acs_node #(
  parameter int unsigned PmW = 8,
  parameter int unsigned BmW = 2
) (
  input  logic [PmW-1:0] pm0_i,
  input  logic [PmW-1:0] pm1_i,
  input  logic [BmW-1:0] bm0_i,
  input  logic [BmW-1:0] bm1_i,
  output logic [PmW-1:0] pm_o,
  output logic           dec_o
);

  logic [PmW-1:0] c0;
  logic [PmW-1:0] c1;

  // Headroom guarantees the sums never wrap, so PmW-bit adders are exact.
  always_comb begin
    c0    = pm0_i + {{(PmW - BmW){1'b0}}, bm0_i};
    c1    = pm1_i + {{(PmW - BmW){1'b0}}, bm1_i};
    dec_o = (c1 < c0);
    pm_o  = dec_o ? c1 : c0;
  end

endmodule

// File: rtl/acs_pm_bank.sv
// 64-way add-compare-select with registered path metrics and MSB renormalisation.
module acs_pm_bank #(
  parameter int unsigned  K          = viterbi_pkg::K,
  parameter int unsigned  PM_W       = viterbi_pkg::PM_W,
  parameter int unsigned  INIT_PM    = viterbi_pkg::INIT_PM,
  localparam int unsigned NUM_STATES = 2 ** (K - 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  input  logic [2*NUM_STATES-1:0] bm_u0,
  input  logic [2*NUM_STATES-1:0] bm_u1,
  output logic                    out_valid,
  output logic [NUM_STATES-1:0]   dec_bits,
  output logic                    norm_pulse
);
  import viterbi_pkg::BM_W, viterbi_pkg::pred0, viterbi_pkg::pred1;

  logic [PM_W-1:0]       pm_q   [NUM_STATES];
  logic [PM_W-1:0]       pm_d   [NUM_STATES];
  logic [PM_W-1:0]       new_pm [NUM_STATES];
  logic [NUM_STATES-1:0] dec_w;
  logic [NUM_STATES-1:0] msb_w;
  logic [NUM_STATES-1:0] dec_q, dec_d;
  logic                  norm_w, norm_q, norm_d;
  logic                  valid_q, valid_d;
  logic                  step;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam int unsigned P0 = pred0(n);
    localparam int unsigned P1 = pred1(n, NUM_STATES);
    logic [BM_W-1:0] bm0;
    logic [BM_W-1:0] bm1;

    // The input bit driving the transition into n is n's LSB.
    if (n % 2 == 0) begin : g_u0
      assign bm0 = bm_u0[BM_W*P0 +: BM_W];
      assign bm1 = bm_u0[BM_W*P1 +: BM_W];
    end else begin : g_u1
      assign bm0 = bm_u1[BM_W*P0 +: BM_W];
      assign bm1 = bm_u1[BM_W*P1 +: BM_W];
    end

    acs_node #(
      .PmW(PM_W),
      .BmW(BM_W)
    ) u_node (
      .pm0_i(pm_q[P0]),
      .pm1_i(pm_q[P1]),
      .bm0_i(bm0),
      .bm1_i(bm1),
      .pm_o (new_pm[n]),
      .dec_o(dec_w[n])
    );

    assign msb_w[n] = new_pm[n][PM_W-1];
  end

  assign norm_w = &msb_w;
  assign step   = in_valid & ~sync_clr;

  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      pm_d[i] = pm_q[i];
      if (sync_clr) begin
        pm_d[i] = (i == 0) ? '0 : PM_W'(INIT_PM);
      end else if (in_valid) begin
        pm_d[i] = new_pm[i];
        if (norm_w) pm_d[i][PM_W-1] = 1'b0;
      end
    end
    valid_d = step;
    dec_d   = step ? dec_w : dec_q;
    norm_d  = step ? norm_w : norm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i] <= (i == 0) ? '0 : PM_W'(INIT_PM);
      end
      valid_q <= 1'b0;
      dec_q   <= '0;
      norm_q  <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      valid_q <= valid_d;
      dec_q   <= dec_d;
      norm_q  <= norm_d;
    end
  end

  assign out_valid  = valid_q;
  assign dec_bits   = dec_q;
  assign norm_pulse = norm_q;

endmodule

// File: tb/tb_acs_pm_bank.sv
// Scoreboard bench for acs_pm_bank against an array-based Viterbi ACS reference model.
module tb_acs_pm_bank;

  localparam int NS = 64;

  typedef struct {
    logic          valid;
    logic [NS-1:0] dec;
    logic          norm;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            sync_clr;
  logic            in_valid;
  logic [2*NS-1:0] bm_u0;
  logic [2*NS-1:0] bm_u1;
  logic            out_valid;
  logic [NS-1:0]   dec_bits;
  logic            norm_pulse;

  int       vectors;
  int       miscompares;
  exp_t     exp_q[$];
  int       pm[NS];
  logic [NS-1:0] last_dec;
  logic     last_norm;

  acs_pm_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .bm_u0     (bm_u0),
    .bm_u1     (bm_u1),
    .out_valid (out_valid),
    .dec_bits  (dec_bits),
    .norm_pulse(norm_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int bm_of(input logic [2*NS-1:0] b, input int s);
    return int'(b[2*s +: 2]);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) pm[s] = (s == 0) ? 0 : 16;
  endtask

  // Apply one cycle of stimulus and enqueue what the outputs must look like after the edge.
  task automatic step(input logic sclr, input logic iv,
                      input logic [2*NS-1:0] b0, input logic [2*NS-1:0] b1);
    int   nw[NS];
    logic [NS-1:0] d;
    bit   all_hi;
    exp_t e;
    @(negedge clk);
    sync_clr = sclr;
    in_valid = iv;
    bm_u0    = b0;
    bm_u1    = b1;
    if (sclr) begin
      model_clear();
      e = '{valid: 1'b0, dec: last_dec, norm: last_norm};
    end else if (iv) begin
      all_hi = 1'b1;
      for (int n = 0; n < NS; n++) begin
        int a, b, c0, c1;
        a  = n / 2;
        b  = n / 2 + NS / 2;
        c0 = pm[a] + ((n % 2 == 1) ? bm_of(b1, a) : bm_of(b0, a));
        c1 = pm[b] + ((n % 2 == 1) ? bm_of(b1, b) : bm_of(b0, b));
        d[n]  = (c1 < c0);
        nw[n] = (c1 < c0) ? c1 : c0;
        if (nw[n] < 128) all_hi = 1'b0;
      end
      for (int n = 0; n < NS; n++) pm[n] = all_hi ? nw[n] - 128 : nw[n];
      last_dec  = d;
      last_norm = all_hi;
      e = '{valid: 1'b1, dec: d, norm: all_hi};
    end else begin
      e = '{valid: 1'b0, dec: last_dec, norm: last_norm};
    end
    exp_q.push_back(e);
  endtask

  // Monitor: every post-edge sample with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", NS'(out_valid), NS'(e.valid));
        chk("dec_bits", dec_bits, e.dec);
        chk("norm_pulse", NS'(norm_pulse), NS'(e.norm));
      end
    end
  end

  initial begin
    logic [2*NS-1:0] zero_b, one_b, two_b, r0, r1;
    vectors     = 0;
    miscompares = 0;
    zero_b = '0;
    one_b  = {NS{2'b01}};
    two_b  = {NS{2'b10}};
    rst_n    = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b1;
    bm_u0    = '0;
    bm_u1    = '0;
    last_dec  = '0;
    last_norm = 1'b0;
    model_clear();

    // Power-on reset.
    #12;
    chk("reset out_valid", NS'(out_valid), '0);
    chk("reset dec_bits", dec_bits, '0);
    chk("reset norm_pulse", NS'(norm_pulse), '0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Metrics straight out of reset, no clear.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, two_b, zero_b);

    // Single step after clear: p0 wins everywhere.
    step(1'b1, 1'b0, zero_b, zero_b);
    step(1'b0, 1'b1, two_b, zero_b);
    step(1'b0, 1'b0, zero_b, zero_b);

    // Ties with all-zero branch metrics.
    step(1'b1, 1'b0, zero_b, zero_b);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, zero_b, zero_b);

    // Renormalisation at step 128 of a constant-bm run.
    step(1'b1, 1'b0, zero_b, zero_b);
    for (int i = 0; i < 135; i++) step(1'b0, 1'b1, one_b, one_b);

    // Clear beats simultaneous valid.
    step(1'b1, 1'b1, one_b, two_b);
    step(1'b0, 1'b1, two_b, one_b);

    // Mid-stream asynchronous reset with in_valid held.
    step(1'b0, 1'b1, one_b, zero_b);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", NS'(out_valid), '0);
    chk("async reset dec_bits", dec_bits, '0);
    chk("async reset norm_pulse", NS'(norm_pulse), '0);
    exp_q.delete();
    model_clear();
    last_dec  = '0;
    last_norm = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, two_b, one_b);

    // Random gapped traffic with occasional clears.
    for (int i = 0; i < 4000; i++) begin
      for (int s = 0; s < NS; s++) begin
        r0[2*s +: 2] = 2'($urandom_range(0, 2));
        r1[2*s +: 2] = 2'($urandom_range(0, 2));
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), r0, r1);
    end

    step(1'b0, 1'b0, zero_b, zero_b);
    step(1'b0, 1'b0, zero_b, zero_b);
    @(posedge clk);
    #2;
    chk("scoreboard drained", NS'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
